shadow_stack_unit: RTL and testbench
====================================

// Module: shadow_stack_unit
// PURPOSE
//  Backward-edge CFI checker on the architectural commit path. Pushes the link address of committed
//  calls and pops it on committed returns. A return whose target differs from top-of-stack raises
//  ss_popchk_ex_o, which the commit stage takes as a port-0 exception. Sits beside the scoreboard
//  and feeds the commit stage.
// PARAMETERS
//  NR_COMMIT_PORTS  2   commit ports observed; port 0 is the only checked port
//  SS_DEPTH         16  on-chip stack entries, power of two, >=2
//  LOST_W           8   width of saturating dropped-entry counter
// PORTS
//  clk_i           in   1                  clock
//  rst_ni          in   1                  asynchronous active-low reset
//  en_i            in   1                  CSR enable; low = disabled and stack cleared
//  flush_i         in   1                  pipeline flush from controller (exception/trap taken)
//  commit_instr_i  in   NR_COMMIT_PORTS x scoreboard_entry_t   scoreboard head entries
//  commit_ack_i    in   NR_COMMIT_PORTS    commit stage retired that entry this cycle
//  target_i        in   NR_COMMIT_PORTS x VLEN   resolved jump target per commit entry
//  ss_popchk_ex_o  out  exception_t        valid/cause/tval to commit stage (combinational)
//  hold_port1_o    out  1                  port-1 entry is call/return; commit stage must not retire it
//  depth_o         out  $clog2(SS_DEPTH)+1 live entries (CSR readable)
//  lost_o          out  LOST_W             entries dropped by overflow, saturating
// BEHAVIOUR
//  Classification, in the package: is_call = JAL/JALR with rd in {x1,x5}. is_ret = JALR with rs1 in
//   {x1,x5} and rd not in {x1,x5}. coroutine = JALR with rd and rs1 both link registers and rd!=rs1;
//   treated as ret followed by call. Link address = pc + (is_compressed ? 2 : 4), VLEN bits,
//   wrapping.
//  FSM ss_state_e: IDLE, ACTIVE, FAULT. Reset -> IDLE.
//   IDLE->ACTIVE when en_i. Any state->IDLE when !en_i; this clears sp, count and lost in that
//   cycle. ACTIVE->FAULT on a cycle where ss_popchk_ex_o.valid. FAULT->ACTIVE on flush_i.
//  Reset values: sp=0, count=0, lost=0, ss_popchk_ex_o='0, hold_port1_o=0, depth_o=0, lost_o=0.
//  Check is combinational, ACTIVE only, when commit_instr_i[0].valid, no earlier ex, and is_ret or
//   coroutine:
//   - count>0 and target_i[0]!=TOS -> fault.
//   - count==0 and lost==0 -> fault (underflow).
//   - count==0 and lost>0 -> no check; lost decrements on ack (permissive after overflow).
//   - fault drives valid=1, cause=SS_CHECK_FAULT, tval=target_i[0].
//  Update on the clock edge, ACTIVE only, no fault this cycle. Port 0 is processed first, then
//   port 1:
//   - ack & ret: pop.
//   - ack & call: push link address.
//   - coroutine: pop, then push.
//   - Push when full: circular overwrite of oldest entry; count stays SS_DEPTH; lost +1, saturating.
//  hold_port1_o = ACTIVE & commit_instr_i[1].valid & (is_call|is_ret). This holds the entry so it
//   reaches port 0 next cycle. Port-1 acks of such entries are therefore never expected; if one
//   occurs, assert in simulation.
//  FAULT: stack frozen, all acks ignored, ss_popchk_ex_o.valid=0.
//  flush_i in ACTIVE: no effect on the stack, since the stack holds committed state only.
//  Two pushes in one cycle: two writes, sp+2 mod SS_DEPTH.
//  Pop on port 0 plus push on port 1: net sp unchanged, TOS replaced.
//  Reset mid-operation: asynchronous return to reset values; no partial update.
// STRUCTURE
//  ariane_pkg: SS_CHECK_FAULT cause (custom, 24), ss_state_e, is_call()/is_ret()/is_coroutine()
//   functions.
//  Sub-module ss_lifo: circular register array with push/pop/two-push ports, TOS, count and
//   overflow strobe.
//  Top: classification, check comparator, FSM, lost counter.
// TESTING
//  1 en=1; commit call at pc 0x8000_0000 (RVI), then ret with target 0x8000_0004 -> no ex; depth 1 then 0.
//  2 Call at 0x100 (compressed), ret with target 0x104 -> ex valid, cause 24, tval 0x104; FSM FAULT;
//    acks ignored until flush_i; depth still 1.
//  3 SS_DEPTH+3 calls, then SS_DEPTH+3 matching rets -> lost_o=3; first SS_DEPTH rets checked and pass;
//    last 3 unchecked; lost_o returns to 0.
//  4 Ret with empty stack and lost=0 -> ex valid, cause 24.
//  5 Port 0 ALU, port 1 call -> hold_port1_o=1, no push; next cycle the call on port 0 is pushed.
//  6 Coroutine JALR x1,x5 at 0x200 with TOS=0x300, target=0x300 -> no ex; TOS becomes 0x204; depth unchanged.
//  7 en_i low mid-stream with depth 5 -> next cycle depth_o=0, lost_o=0, IDLE.
//  8 Assert rst_ni during a push -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shadow_stack_unit_pkg.sv
// Shared types and helpers for the shadow stack unit.
// Contents:
//   VLEN / XLEN          address and exception-field widths
//   SS_CHECK_FAULT       custom exception cause for a failed return check (24)
//   ss_state_e           checker FSM states
//   jump_op_e            reduced opcode classes seen at commit
//   scoreboard_entry_t   subset of a scoreboard entry observed at commit
//   exception_t          valid/cause/tval bundle handed to the commit stage
//   is_call/is_ret/is_coroutine/link_addr   control-transfer classification
package shadow_stack_unit_pkg;

    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;

    localparam logic [XLEN-1:0] SS_CHECK_FAULT = 64'd24;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FAULT
    } ss_state_e;

    typedef enum logic [1:0] {
        OP_OTHER,
        OP_JAL,
        OP_JALR
    } jump_op_e;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        jump_op_e        op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic            is_compressed;
        logic            ex_valid;
    } scoreboard_entry_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    // x1 (ra) and x5 (t0) are the RISC-V link registers.
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic is_call(input scoreboard_entry_t e);
        return ((e.op == OP_JAL) || (e.op == OP_JALR)) && is_link(e.rd);
    endfunction

    function automatic logic is_ret(input scoreboard_entry_t e);
        return (e.op == OP_JALR) && is_link(e.rs1) && !is_link(e.rd);
    endfunction

    // Coroutine swap: pops the old link then pushes the new one.
    function automatic logic is_coroutine(input scoreboard_entry_t e);
        return (e.op == OP_JALR) && is_link(e.rd) && is_link(e.rs1) && (e.rd != e.rs1);
    endfunction

    function automatic logic [VLEN-1:0] link_addr(input scoreboard_entry_t e);
        return e.pc + (e.is_compressed ? VLEN'(2) : VLEN'(4));
    endfunction

endpackage

// File: rtl/shadow_stack_unit_ss_lifo.sv
// Circular return-address stack.
// Each cycle applies, in order: an optional pop, then up to two pushes
// (push_b is only meaningful together with push_a). Pushing into a full
// stack overwrites the oldest entry and keeps count at DEPTH.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous clear of pointer and count
//   pop                 remove TOS (no effect when empty; reported on underflow)
//   push_a, data_a      first push of the cycle
//   push_b, data_b      second push of the cycle
//   tos                 current top of stack (undefined when count == 0)
//   count               live entries, 0..DEPTH
//   underflow           pop requested on an empty stack this cycle
//   overflow            number of entries overwritten this cycle (0..2)
module shadow_stack_unit_ss_lifo
    import shadow_stack_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = VLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     pop,
    input  logic                     push_a,
    input  logic [WIDTH-1:0]         data_a,
    input  logic                     push_b,
    input  logic [WIDTH-1:0]         data_b,
    output logic [WIDTH-1:0]         tos,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow,
    output logic [1:0]               overflow
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp_q, sp_pop, sp_a, sp_b;
    logic [PW:0]      count_q, cnt_pop, cnt_a, cnt_b;
    logic             ovf_a, ovf_b;
    logic [PW-1:0]    tos_idx;

    // sp points at the next free slot; arithmetic wraps because DEPTH is a power of two.
    always_comb begin
        underflow = pop && (count_q == '0);

        sp_pop  = sp_q;
        cnt_pop = count_q;
        if (pop && (count_q != '0)) begin
            sp_pop  = sp_q - 1'b1;
            cnt_pop = count_q - 1'b1;
        end

        sp_a  = sp_pop;
        cnt_a = cnt_pop;
        ovf_a = 1'b0;
        if (push_a) begin
            sp_a = sp_pop + 1'b1;
            if (cnt_pop == FULL) begin
                ovf_a = 1'b1;
            end else begin
                cnt_a = cnt_pop + 1'b1;
            end
        end

        sp_b  = sp_a;
        cnt_b = cnt_a;
        ovf_b = 1'b0;
        if (push_a && push_b) begin
            sp_b = sp_a + 1'b1;
            if (cnt_a == FULL) begin
                ovf_b = 1'b1;
            end else begin
                cnt_b = cnt_a + 1'b1;
            end
        end

        overflow = {1'b0, ovf_a} + {1'b0, ovf_b};
        tos_idx  = sp_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
        end else if (clear) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_b;
            count_q <= cnt_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && push_a) begin
            mem[sp_pop] <= data_a;
        end
        if (!clear && push_a && push_b) begin
            mem[sp_a] <= data_b;
        end
    end

    assign tos   = mem[tos_idx];
    assign count = count_q;

endmodule

// File: rtl/shadow_stack_unit.sv
// Backward-edge CFI checker on the commit path.
// Pushes link addresses of committed calls, pops on committed returns and
// flags a return whose target differs from the top of stack as a port-0
// exception. After an overflow, returns on an empty stack are accepted
// while the dropped-entry count drains.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i               enable; low disables the checker and clears the stack
//   flush_i            controller flush; leaves FAULT
//   commit_instr_i     scoreboard head entries per commit port
//   commit_ack_i       entry retired this cycle, per port
//   target_i           resolved jump target per port
//   ss_popchk_ex_o     return-check exception (combinational)
//   hold_port1_o       port-1 entry is call/return and must not retire on port 1
//   depth_o            live stack entries
//   lost_o             saturating count of entries lost to overflow
module shadow_stack_unit
    import shadow_stack_unit_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned SS_DEPTH        = 16,
    parameter int unsigned LOST_W          = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  scoreboard_entry_t          commit_instr_i [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  logic [VLEN-1:0]            target_i [NR_COMMIT_PORTS],
    output exception_t                 ss_popchk_ex_o,
    output logic                       hold_port1_o,
    output logic [$clog2(SS_DEPTH):0]  depth_o,
    output logic [LOST_W-1:0]          lost_o
);

    localparam int unsigned CW = $clog2(SS_DEPTH) + 1;

    ss_state_e         state_q, state_d;
    logic [LOST_W-1:0] lost_q, lost_next;
    logic [LOST_W:0]   lost_sum;
    logic              lost_dec;

    logic              active;
    logic              v0, v1;
    logic              call0, ret0, cor0, call1, ret1, cor1;
    logic [VLEN-1:0]   link0, link1;
    logic              fault;
    logic              upd;
    logic              p0_pop, p0_push, p1_pop, p1_push;

    logic              lifo_pop, lifo_push_a, lifo_push_b;
    logic [VLEN-1:0]   lifo_data_a, lifo_data_b;
    logic [VLEN-1:0]   tos;
    logic [CW-1:0]     count;
    logic              lifo_underflow;
    logic [1:0]        lifo_overflow;

    logic              unused_targets;

    // ---------------- classification ----------------
    always_comb begin
        active = (state_q == ACTIVE);
        v0     = commit_instr_i[0].valid && !commit_instr_i[0].ex_valid;
        v1     = commit_instr_i[1].valid && !commit_instr_i[1].ex_valid;
        call0  = is_call(commit_instr_i[0]);
        ret0   = is_ret(commit_instr_i[0]);
        cor0   = is_coroutine(commit_instr_i[0]);
        call1  = is_call(commit_instr_i[1]);
        ret1   = is_ret(commit_instr_i[1]);
        cor1   = is_coroutine(commit_instr_i[1]);
        link0  = link_addr(commit_instr_i[0]);
        link1  = link_addr(commit_instr_i[1]);
    end

    // Only port 0 is ever checked; upper-port targets are never consulted.
    always_comb begin
        unused_targets = 1'b0;
        for (int unsigned p = 1; p < NR_COMMIT_PORTS; p++) begin
            unused_targets = unused_targets ^ (^target_i[p]);
        end
    end

    // ---------------- return check ----------------
    always_comb begin
        fault = 1'b0;
        if (active && v0 && (ret0 || cor0)) begin
            if (count != '0) begin
                fault = (target_i[0] != tos);
            end else begin
                fault = (lost_q == '0);
            end
        end

        ss_popchk_ex_o = '0;
        if (fault) begin
            ss_popchk_ex_o.valid = 1'b1;
            ss_popchk_ex_o.cause = SS_CHECK_FAULT;
            ss_popchk_ex_o.tval  = target_i[0];
        end

        hold_port1_o = active && commit_instr_i[1].valid && (call1 || ret1);
    end

    // ---------------- stack update ----------------
    // Port 0 then port 1, folded onto a pop-then-two-push LIFO. A port-0 push
    // followed by a port-1 pop cancels without touching the array. A second
    // pop in one cycle is not representable; port-1 returns are held back,
    // so that combination only arises from a protocol violation.
    always_comb begin
        upd     = active && en_i && !fault;
        p0_pop  = upd && commit_ack_i[0] && v0 && (ret0 || cor0);
        p0_push = upd && commit_ack_i[0] && v0 && call0;
        p1_pop  = upd && commit_ack_i[1] && v1 && (ret1 || cor1);
        p1_push = upd && commit_ack_i[1] && v1 && call1;

        lifo_pop    = p0_pop;
        lifo_push_a = 1'b0;
        lifo_push_b = 1'b0;
        lifo_data_a = link0;
        lifo_data_b = link1;

        if (p1_pop && p0_push) begin
            lifo_push_a = p1_push;
            lifo_data_a = link1;
        end else if (p1_pop) begin
            lifo_pop    = 1'b1;
            lifo_push_a = p1_push;
            lifo_data_a = link1;
        end else if (p0_push) begin
            lifo_push_a = 1'b1;
            lifo_push_b = p1_push;
        end else begin
            lifo_push_a = p1_push;
            lifo_data_a = link1;
        end
    end

    shadow_stack_unit_ss_lifo #(
        .DEPTH (SS_DEPTH),
        .WIDTH (VLEN)
    ) u_lifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (!en_i),
        .pop       (lifo_pop),
        .push_a    (lifo_push_a),
        .data_a    (lifo_data_a),
        .push_b    (lifo_push_b),
        .data_b    (lifo_data_b),
        .tos       (tos),
        .count     (count),
        .underflow (lifo_underflow),
        .overflow  (lifo_overflow)
    );

    // ---------------- lost counter ----------------
    // An unchecked return on an empty stack consumes one dropped entry.
    always_comb begin
        lost_dec  = lifo_underflow && (lost_q != '0);
        lost_sum  = {1'b0, lost_q} - (LOST_W+1)'(lost_dec) + (LOST_W+1)'(lifo_overflow);
        lost_next = lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ACTIVE;
                ACTIVE:  if (fault)   state_d = FAULT;
                FAULT:   if (flush_i) state_d = ACTIVE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            lost_q  <= en_i ? lost_next : '0;
        end
    end

    assign depth_o = count;
    assign lost_o  = lost_q;

    a_no_port1_cfi_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hold_port1_o && commit_ack_i[1]));

endmodule

// File: tb/tb_shadow_stack_unit.sv
module tb_shadow_stack_unit;
    import shadow_stack_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    scoreboard_entry_t instr [2];
    logic [1:0]        ack;
    logic [63:0]       target [2];
    exception_t        ex;
    logic              hold;
    logic [4:0]        depth;
    logic [7:0]        lost;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string     name;
        logic      exv;
        logic [63:0] tval;
        logic      hold;
        int        depth;
        int        lost;
        ss_state_e st;
    } exp_t;

    exp_t q[$];

    shadow_stack_unit #(
        .NR_COMMIT_PORTS (2),
        .SS_DEPTH        (16),
        .LOST_W          (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .flush_i        (flush),
        .commit_instr_i (instr),
        .commit_ack_i   (ack),
        .target_i       (target),
        .ss_popchk_ex_o (ex),
        .hold_port1_o   (hold),
        .depth_o        (depth),
        .lost_o         (lost)
    );

    always #5 clk = ~clk;

    function automatic scoreboard_entry_t mk(input jump_op_e op, input logic [63:0] pc,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic c);
        scoreboard_entry_t e;
        e = '0;
        e.valid = 1'b1;
        e.op = op;
        e.pc = pc;
        e.rd = rd;
        e.rs1 = rs1;
        e.is_compressed = c;
        return e;
    endfunction

    function automatic scoreboard_entry_t call_e(input logic [63:0] pc, input logic c);
        return mk(OP_JAL, pc, 5'd1, 5'd0, c);
    endfunction

    function automatic scoreboard_entry_t ret_e();
        return mk(OP_JALR, 64'h0, 5'd0, 5'd1, 1'b0);
    endfunction

    localparam scoreboard_entry_t NONE = '0;

    // rst_mode: 0 = run, 1 = held in reset, 2 = reset asserted mid-cycle after drive
    task automatic step(input string name,
                        input scoreboard_entry_t e0, input logic a0, input logic [63:0] t0,
                        input scoreboard_entry_t e1, input logic a1,
                        input logic en_v, input logic fl, input int rst_mode,
                        input logic exv, input logic [63:0] tv, input logic hd,
                        input int dp, input int ls, input ss_state_e st);
        exp_t x;
        @(posedge clk);
        #1;
        instr[0]  = e0;
        ack[0]    = a0;
        target[0] = t0;
        instr[1]  = e1;
        ack[1]    = a1;
        target[1] = 64'h0;
        en        = en_v;
        flush     = fl;
        rst_n     = (rst_mode != 1);
        x.name = name; x.exv = exv; x.tval = tv; x.hold = hd;
        x.depth = dp; x.lost = ls; x.st = st;
        q.push_back(x);
        if (rst_mode == 2) begin
            #1;
            rst_n = 1'b0;
        end
    endtask

    task automatic cmp(input string nm, input string f, input logic [63:0] act, input logic [63:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, once per issued stimulus step.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() != 0) begin
            x = q.pop_front();
            cmp(x.name, "ex_valid", 64'(ex.valid), 64'(x.exv));
            cmp(x.name, "ex_cause", ex.cause, x.exv ? 64'd24 : 64'd0);
            cmp(x.name, "ex_tval", ex.tval, x.exv ? x.tval : 64'd0);
            cmp(x.name, "hold", 64'(hold), 64'(x.hold));
            cmp(x.name, "depth", 64'(depth), 64'(x.depth));
            cmp(x.name, "lost", 64'(lost), 64'(x.lost));
            cmp(x.name, "state", 64'(dut.state_q), 64'(x.st));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instr[0] = '0; instr[1] = '0; ack = '0;
        target[0] = '0; target[1] = '0;

        // Reset held: outputs quiet even with a ret on port 0 and a call on port 1
        step("rst", ret_e(), 1, 64'h99, call_e(64'h20, 0), 0, 1, 0, 1, 0, 0, 0, 0, 0, IDLE);
        step("idle", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);

        // 1: matching call/ret
        step("t1_call", call_e(64'h8000_0000, 0), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);
        step("t1_ret", ret_e(), 1, 64'h8000_0004, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, ACTIVE);
        step("t1_after", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 2: compressed call, wrong return target, FAULT until flush
        step("t2_call", call_e(64'h100, 1), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);
        step("t2_ret_bad", ret_e(), 1, 64'h104, NONE, 0, 1, 0, 0, 1, 64'h104, 0, 1, 0, ACTIVE);
        step("t2_fault_ret", ret_e(), 1, 64'h102, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, FAULT);
        step("t2_fault_call", call_e(64'h500, 0), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, FAULT);
        step("t2_flush", NONE, 0, 0, NONE, 0, 1, 1, 0, 0, 0, 0, 1, 0, FAULT);
        step("t2_back", ret_e(), 1, 64'h102, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, ACTIVE);
        step("t2_empty", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 3: overflow by 3, then drain; the last return has a bogus target and is unchecked
        for (int i = 0; i < 19; i++) begin
            step("t3_call", call_e(64'h1000 + 64'(16*i), 0), 1, 0, NONE, 0, 1, 0, 0,
                 0, 0, 0, (i < 16) ? i : 16, (i > 16) ? i - 16 : 0, ACTIVE);
        end
        for (int j = 18; j >= 0; j--) begin
            step("t3_ret", ret_e(), 1, (j == 0) ? 64'hdead : 64'h1004 + 64'(16*j), NONE, 0, 1, 0, 0,
                 0, 0, 0, (j >= 3) ? j - 2 : 0, (j >= 3) ? 3 : j + 1, ACTIVE);
        end
        step("t3_done", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 4: underflow with no lost entries
        step("t4_underflow", ret_e(), 1, 64'h500, NONE, 0, 1, 0, 0, 1, 64'h500, 0, 0, 0, ACTIVE);
        step("t4_flush", NONE, 0, 0, NONE, 0, 1, 1, 0, 0, 0, 0, 0, 0, FAULT);
        step("t4_back", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 5: port-1 call/ret is held and later pushed from port 0
        step("t5_hold", mk(OP_OTHER, 64'h3fc, 5'd3, 5'd4, 0), 1, 0, call_e(64'h400, 0), 0,
             1, 0, 0, 0, 0, 1, 0, 0, ACTIVE);
        step("t5_port0", call_e(64'h400, 0), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);
        step("t5_hold_ret", mk(OP_OTHER, 64'h404, 5'd3, 5'd4, 0), 1, 0, ret_e(), 0,
             1, 0, 0, 0, 0, 1, 1, 0, ACTIVE);
        step("t5_pop", ret_e(), 1, 64'h404, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, ACTIVE);

        // 6: coroutine swaps TOS 0x300 -> 0x204
        step("t6_call", call_e(64'h2fc, 0), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);
        step("t6_cor", mk(OP_JALR, 64'h200, 5'd1, 5'd5, 0), 1, 64'h300, NONE, 0,
             1, 0, 0, 0, 0, 0, 1, 0, ACTIVE);
        step("t6_ret", ret_e(), 1, 64'h204, NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0, ACTIVE);
        step("t6_done", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 7: lost saturation, flush in ACTIVE, then disable clears everything
        for (int i = 0; i < 274; i++) begin
            step("t7_call", call_e(64'h600 + 64'(4*i), 0), 1, 0, NONE, 0, 1, 0, 0,
                 0, 0, 0, (i < 16) ? i : 16, (i <= 16) ? 0 : ((i - 16 > 255) ? 255 : i - 16), ACTIVE);
        end
        step("t7_flush", NONE, 0, 0, NONE, 0, 1, 1, 0, 0, 0, 0, 16, 255, ACTIVE);
        step("t7_en_low", call_e(64'h700, 0), 1, 0, NONE, 0, 0, 0, 0, 0, 0, 0, 16, 255, ACTIVE);
        step("t7_cleared", NONE, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("t7_reen", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("t7_active", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        // 8: asynchronous reset during a push
        step("t8_call", call_e(64'h800, 0), 1, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);
        step("t8_rst", call_e(64'h804, 0), 1, 0, call_e(64'h808, 0), 0, 1, 0, 2,
             0, 0, 0, 0, 0, IDLE);
        step("t8_release", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("t8_active", NONE, 0, 0, NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0, ACTIVE);

        @(negedge clk);
        #1;
        n_run++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
